ppu_write_scheduler: RTL and testbench



---
 rtl/ppu_write_scheduler.sv | 151 +++++++++++++++
 tb/tb_ppu_write_scheduler.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_write_scheduler.sv
// Host-write scheduler: queues Avalon writes to the PPU tables and
// drains them into the tables only during vertical blanking.
module ppu_write_scheduler #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     chipselect,
    input  logic                     write,
    input  logic [15:0]              address,
    input  logic [31:0]              writedata,
    output logic                     waitrequest,
    input  logic [10:0]              hcount,
    input  logic [9:0]               vcount,
    output logic [2:0]               mem_write,
    output logic [7:0]               w_addr,
    output logic [31:0]              w_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     pending
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    typedef enum logic {
        S_WAIT,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic [1:0]  sel;
        logic [7:0]  idx;
        logic [31:0] data;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   level_q;
    logic [AW:0]   level_d;
    state_t        state_q;
    logic [2:0]    mem_write_q;
    logic [7:0]    w_addr_q;
    logic [31:0]   w_data_q;

    logic   accept;
    logic   is_ctrl;
    logic   push;
    logic   flush;
    logic   drain_ok;
    logic   pop;
    entry_t head;
    logic   unused_addr;

    assign unused_addr = ^address[15:10];

    assign waitrequest = (level_q == FULL);
    assign pending     = (level_q != '0);
    assign level       = level_q;
    assign mem_write   = mem_write_q;
    assign w_addr      = w_addr_q;
    assign w_data      = w_data_q;

    assign accept  = chipselect && write && !waitrequest;
    assign is_ctrl = (address[9:8] == 2'b11);
    assign push    = accept && !is_ctrl;
    assign flush   = accept && is_ctrl && writedata[0];

    // Stop short of the line-0 attribute scan at the end of line 524
    assign drain_ok = (vcount >= 10'd480) &&
                      !(vcount == 10'd524 && hcount >= 11'd1272);

    assign pop  = (state_q == S_DRAIN) && drain_ok && pending;
    assign head = fifo_q[rptr_q];

    // Next occupancy: flush wins, otherwise push/pop cancel out
    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + ONE;
        end else if (!push && pop) begin
            level_d = level_q - ONE;
        end
        if (flush) begin
            level_d = '0;
        end
    end

    // Queue storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= {address[9:8], address[7:0], writedata};
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            level_q <= level_d;
            if (flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push) begin
                    wptr_q <= wptr_q + 1'b1;
                end
                if (pop) begin
                    rptr_q <= rptr_q + 1'b1;
                end
            end
        end
    end

    // Drain FSM with registered single-cycle table write pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_WAIT;
            mem_write_q <= '0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
        end else begin
            mem_write_q <= '0;
            unique case (state_q)
                S_WAIT: begin
                    if (drain_ok && pending && !flush) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop) begin
                        mem_write_q <= 3'b001 << head.sel;
                        w_addr_q    <= head.idx;
                        w_data_q    <= head.data;
                        if (flush) begin
                            state_q <= S_WAIT;
                        end
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                default: state_q <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_write_scheduler.sv
// Randomized self-checking bench for ppu_write_scheduler.
// Expected pulses come from a queue of issued writes.
module tb_ppu_write_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic [15:0] address = '0;
    logic [31:0] writedata = '0;
    logic        waitrequest;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic [2:0]  mem_write;
    logic [7:0]  w_addr;
    logic [31:0] w_data;
    logic [3:0]  level;
    logic        pending;

    ppu_write_scheduler #(.DEPTH(8)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .chipselect(chipselect),
        .write(write),
        .address(address),
        .writedata(writedata),
        .waitrequest(waitrequest),
        .hcount(hcount),
        .vcount(vcount),
        .mem_write(mem_write),
        .w_addr(w_addr),
        .w_data(w_data),
        .level(level),
        .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  mw;
        logic [7:0]  a;
        logic [31:0] d;
        int          cyc;
        int          hc;
        int          vc;
    } pulse_t;

    pulse_t plog[$];
    pulse_t exp_q[$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    bit     run_cnt = 1'b0;

    function automatic pulse_t mk(input logic [15:0] a, input logic [31:0] d);
        pulse_t p;
        case (a[9:8])
            2'd0:    p.mw = 3'b001;
            2'd1:    p.mw = 3'b010;
            default: p.mw = 3'b100;
        endcase
        p.a = a[7:0];
        p.d = d;
        p.cyc = 0;
        p.hc = 0;
        p.vc = 0;
        return p;
    endfunction

    function automatic logic [15:0] rnd_addr();
        logic [1:0] s;
        logic [7:0] i;
        s = 2'($urandom_range(0, 2));
        i = 8'($urandom);
        return {6'd0, s, i};
    endfunction

    task automatic tick();
        pulse_t p;
        @(posedge clk);
        #1;
        cyc++;
        if (mem_write !== 3'b000) begin
            p.mw = mem_write;
            p.a = w_addr;
            p.d = w_data;
            p.cyc = cyc;
            p.hc = int'(hcount);
            p.vc = int'(vcount);
            plog.push_back(p);
        end
        if (run_cnt) begin
            if (hcount == 11'd1599) begin
                hcount = '0;
                vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
            end else begin
                hcount = hcount + 11'd1;
            end
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        int n = 0;
        bit acc = 1'b0;
        chipselect = 1'b1;
        write = 1'b1;
        address = a;
        writedata = d;
        do begin
            acc = !waitrequest;
            tick();
            n++;
        end while (!acc && n < 2000);
        chipselect = 1'b0;
        write = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL wr_accept addr=%h never accepted", a);
        end else if (a[9:8] != 2'b11) begin
            exp_q.push_back(mk(a, d));
        end
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k = 0;
        while (plog.size() < n && k < budget) begin
            tick();
            k++;
        end
        total++;
        if (plog.size() < n) begin
            bad++;
            $display("FAIL wait_pulses got=%0d need=%0d", plog.size(), n);
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        tick();
        tick();
        total++;
        if (mem_write !== 3'b000 || w_addr !== 8'h00 || w_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_out mw=%b a=%h d=%h want 0", mem_write, w_addr, w_data);
        end
        total++;
        if (level !== 4'd0 || pending !== 1'b0 || waitrequest !== 1'b0) begin
            bad++;
            $display("FAIL reset_lvl lvl=%0d pend=%b wr=%b want 0", level, pending, waitrequest);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int c0;
        plog.delete();
        exp_q.delete();
        vcount = 10'd100;
        hcount = '0;
        wr(16'h0003, 32'h1234_5678);
        repeat (20) tick();
        total++;
        if (level !== 4'd1 || pending !== 1'b1 || plog.size() != 0) begin
            bad++;
            $display("FAIL single_hold lvl=%0d pend=%b pulses=%0d want 1/1/0", level, pending, plog.size());
        end
        vcount = 10'd480;
        c0 = cyc;
        repeat (3) tick();
        total++;
        if (plog.size() != 1) begin
            bad++;
            $display("FAIL single_count got=%0d want 1", plog.size());
        end else begin
            total++;
            if (plog[0].cyc != c0 + 2 || plog[0].mw !== 3'b001 ||
                plog[0].a !== 8'h03 || plog[0].d !== 32'h1234_5678) begin
                bad++;
                $display("FAIL single_pulse cyc=%0d mw=%b a=%h d=%h want %0d/001/03/12345678",
                         plog[0].cyc - c0, plog[0].mw, plog[0].a, plog[0].d, 2);
            end
        end
        total++;
        if (level !== 4'd0 || mem_write !== 3'b000) begin
            bad++;
            $display("FAIL single_after lvl=%0d mw=%b want 0/000", level, mem_write);
        end
    endtask

    task automatic test_back_to_back();
        plog.delete();
        exp_q.delete();
        vcount = 10'd490;
        hcount = '0;
        wr(16'h0110, 32'hAAAA_0001);
        wr(16'h0205, 32'hBBBB_0002);
        wr(16'h0001, 32'hCCCC_0003);
        repeat (6) tick();
        total++;
        if (plog.size() != 3) begin
            bad++;
            $display("FAIL b2b_count got=%0d want 3", plog.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (plog[i].mw !== exp_q[i].mw || plog[i].a !== exp_q[i].a ||
                    plog[i].d !== exp_q[i].d || plog[i].cyc != plog[0].cyc + i) begin
                    bad++;
                    $display("FAIL b2b_pulse%0d got=%b/%h/%h want=%b/%h/%h", i,
                             plog[i].mw, plog[i].a, plog[i].d,
                             exp_q[i].mw, exp_q[i].a, exp_q[i].d);
                end
            end
        end
    endtask

    task automatic test_full();
        int c0;
        int n;
        bit acc;
        logic [15:0] a9;
        logic [31:0] d9;
        plog.delete();
        exp_q.delete();
        vcount = 10'd100;
        for (int i = 0; i < 8; i++) wr(rnd_addr(), $urandom);
        total++;
        if (waitrequest !== 1'b1 || level !== 4'd8) begin
            bad++;
            $display("FAIL full_wr wr=%b lvl=%0d want 1/8", waitrequest, level);
        end
        a9 = rnd_addr();
        d9 = $urandom;
        chipselect = 1'b1;
        write = 1'b1;
        address = a9;
        writedata = d9;
        repeat (3) tick();
        total++;
        if (waitrequest !== 1'b1 || level !== 4'd8) begin
            bad++;
            $display("FAIL full_hold wr=%b lvl=%0d want 1/8", waitrequest, level);
        end
        vcount = 10'd480;
        c0 = cyc;
        n = 0;
        acc = 1'b0;
        do begin
            acc = !waitrequest;
            tick();
            n++;
        end while (!acc && n < 50);
        chipselect = 1'b0;
        write = 1'b0;
        exp_q.push_back(mk(a9, d9));
        total++;
        if (!acc || cyc != c0 + 3 || level !== 4'd7) begin
            bad++;
            $display("FAIL full_9th acc=%b at=%0d lvl=%0d want 1/3/7", acc, cyc - c0, level);
        end
        wait_pulses(9, 40);
        repeat (2) tick();
        for (int i = 0; i < 9 && i < plog.size(); i++) begin
            total++;
            if (plog[i].mw !== exp_q[i].mw || plog[i].a !== exp_q[i].a ||
                plog[i].d !== exp_q[i].d || plog[i].cyc != plog[0].cyc + i) begin
                bad++;
                $display("FAIL full_pulse%0d got=%b/%h/%h want=%b/%h/%h", i,
                         plog[i].mw, plog[i].a, plog[i].d,
                         exp_q[i].mw, exp_q[i].a, exp_q[i].d);
            end
        end
        total++;
        if (plog.size() != 9 || level !== 4'd0) begin
            bad++;
            $display("FAIL full_end pulses=%0d lvl=%0d want 9/0", plog.size(), level);
        end
    endtask

    task automatic test_window_edge();
        plog.delete();
        exp_q.delete();
        vcount = 10'd100;
        hcount = '0;
        for (int i = 0; i < 8; i++) wr(rnd_addr(), $urandom);
        vcount = 10'd524;
        hcount = 11'd1267;
        run_cnt = 1'b1;
        repeat (12) tick();
        run_cnt = 1'b0;
        total++;
        if (plog.size() != 4 || level !== 4'd4 || pending !== 1'b1) begin
            bad++;
            $display("FAIL edge_cut pulses=%0d lvl=%0d pend=%b want 4/4/1", plog.size(), level, pending);
        end
        for (int i = 0; i < 4 && i < plog.size(); i++) begin
            total++;
            if (plog[i].hc != 1268 + i || plog[i].vc != 524 ||
                plog[i].a !== exp_q[i].a || plog[i].d !== exp_q[i].d ||
                plog[i].mw !== exp_q[i].mw) begin
                bad++;
                $display("FAIL edge_pulse%0d got h=%0d a=%h d=%h want h=%0d a=%h d=%h", i,
                         plog[i].hc, plog[i].a, plog[i].d, 1268 + i, exp_q[i].a, exp_q[i].d);
            end
        end
        vcount = 10'd479;
        hcount = 11'd1590;
        run_cnt = 1'b1;
        wait_pulses(8, 60);
        repeat (2) tick();
        run_cnt = 1'b0;
        for (int i = 4; i < 8 && i < plog.size(); i++) begin
            total++;
            if (plog[i].vc != 480 || plog[i].a !== exp_q[i].a ||
                plog[i].d !== exp_q[i].d || plog[i].mw !== exp_q[i].mw) begin
                bad++;
                $display("FAIL edge_next%0d got v=%0d a=%h d=%h want v=480 a=%h d=%h", i,
                         plog[i].vc, plog[i].a, plog[i].d, exp_q[i].a, exp_q[i].d);
            end
        end
        total++;
        if (plog.size() != 8 || level !== 4'd0) begin
            bad++;
            $display("FAIL edge_end pulses=%0d lvl=%0d want 8/0", plog.size(), level);
        end
    endtask

    task automatic test_flush();
        plog.delete();
        exp_q.delete();
        vcount = 10'd100;
        hcount = '0;
        for (int i = 0; i < 5; i++) wr(rnd_addr(), $urandom);
        wr(16'h0300, 32'h0);
        tick();
        total++;
        if (level !== 4'd5) begin
            bad++;
            $display("FAIL ctrl_zero lvl=%0d want 5", level);
        end
        vcount = 10'd490;
        tick();
        tick();
        chipselect = 1'b1;
        write = 1'b1;
        address = 16'h0300;
        writedata = 32'h1;
        tick();
        chipselect = 1'b0;
        write = 1'b0;
        repeat (6) tick();
        total++;
        if (plog.size() != 2 || level !== 4'd0 || pending !== 1'b0 || mem_write !== 3'b000) begin
            bad++;
            $display("FAIL flush_end pulses=%0d lvl=%0d pend=%b mw=%b want 2/0/0/000",
                     plog.size(), level, pending, mem_write);
        end
        for (int i = 0; i < 2 && i < plog.size(); i++) begin
            total++;
            if (plog[i].mw !== exp_q[i].mw || plog[i].a !== exp_q[i].a || plog[i].d !== exp_q[i].d) begin
                bad++;
                $display("FAIL flush_pulse%0d got=%b/%h/%h want=%b/%h/%h", i,
                         plog[i].mw, plog[i].a, plog[i].d,
                         exp_q[i].mw, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        plog.delete();
        exp_q.delete();
        vcount = 10'd100;
        for (int i = 0; i < 6; i++) wr(rnd_addr(), $urandom);
        vcount = 10'd490;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        total++;
        if (mem_write !== 3'b000 || level !== 4'd0 || waitrequest !== 1'b0 || pending !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid mw=%b lvl=%0d wr=%b pend=%b want 000/0/0/0",
                     mem_write, level, waitrequest, pending);
        end
        tick();
        reset_n = 1'b1;
        tick();
        plog.delete();
        exp_q.delete();
        wr(rnd_addr(), $urandom);
        wr(rnd_addr(), $urandom);
        wait_pulses(2, 20);
        repeat (2) tick();
        for (int i = 0; i < 2 && i < plog.size(); i++) begin
            total++;
            if (plog[i].mw !== exp_q[i].mw || plog[i].a !== exp_q[i].a || plog[i].d !== exp_q[i].d) begin
                bad++;
                $display("FAIL rst_resume%0d got=%b/%h/%h want=%b/%h/%h", i,
                         plog[i].mw, plog[i].a, plog[i].d,
                         exp_q[i].mw, exp_q[i].a, exp_q[i].d);
            end
        end
        total++;
        if (plog.size() != 2 || level !== 4'd0) begin
            bad++;
            $display("FAIL rst_resume_end pulses=%0d lvl=%0d want 2/0", plog.size(), level);
        end
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 4; r++) begin
            plog.delete();
            exp_q.delete();
            vcount = 10'd100;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                wr(rnd_addr(), $urandom);
                repeat ($urandom_range(0, 2)) tick();
            end
            total++;
            if (level !== 4'(n) || pending !== 1'b1 || plog.size() != 0) begin
                bad++;
                $display("FAIL rnd_fill%0d lvl=%0d pulses=%0d want %0d/0", r, level, plog.size(), n);
            end
            vcount = 10'd500;
            wait_pulses(n, 40);
            repeat (2) tick();
            for (int i = 0; i < n && i < plog.size(); i++) begin
                total++;
                if (plog[i].mw !== exp_q[i].mw || plog[i].a !== exp_q[i].a ||
                    plog[i].d !== exp_q[i].d || plog[i].cyc != plog[0].cyc + i) begin
                    bad++;
                    $display("FAIL rnd%0d_pulse%0d got=%b/%h/%h want=%b/%h/%h", r, i,
                             plog[i].mw, plog[i].a, plog[i].d,
                             exp_q[i].mw, exp_q[i].a, exp_q[i].d);
                end
            end
            total++;
            if (plog.size() != n || level !== 4'd0 || pending !== 1'b0) begin
                bad++;
                $display("FAIL rnd_end%0d pulses=%0d lvl=%0d want %0d/0", r, plog.size(), level, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_window_edge();
        test_flush();
        test_reset_mid_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
